game_time_display: RTL and testbench

- Display-side consumer of the game timer's BCD outputs (ones, tens, hundreds digits and max flag).
- Drives a 3-digit multiplexed common-anode seven-segment display.
- Snapshots the digits once per scan frame so the display never tears, with these features:
  - leading-zero blanking;
  - a dash for non-BCD codes;
  - blinking of the whole display once the timer has saturated.
- Sits between the cartridge timer logic and the board segment/digit-select pins.

---
 rtl/game_time_display_if.sv | 14 +
 rtl/game_time_display.sv | 128 ++++++++++++
 tb/tb_game_time_display.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_time_display_if.sv
// Timer-to-display bundle: BCD digits and saturation flag in, segment/digit-select pins out.
interface game_time_display_if;
  logic [3:0] time_1s;
  logic [3:0] time_10s;
  logic [3:0] time_100s;
  logic       time_max_flag;
  logic [7:0] seg;
  logic [2:0] sel;

  modport master (output time_1s, time_10s, time_100s, time_max_flag,
                  input  seg, sel);
  modport slave  (input  time_1s, time_10s, time_100s, time_max_flag,
                  output seg, sel);
endinterface

// File: rtl/game_time_display.sv
// Three-digit multiplexed common-anode 7-segment driver for the game timer, with
// per-frame snapshot, leading-zero blanking, dash for non-BCD and blink at saturation.

module game_time_digit (
  input  logic [3:0] code,
  input  logic       blank,
  output logic [7:0] pat
);
  // Active-low {dp,g,f,e,d,c,b,a}; dp stays dark.
  always_comb begin
    pat = 8'hBF;
    case (code)
      4'd0:    pat = 8'hC0;
      4'd1:    pat = 8'hF9;
      4'd2:    pat = 8'hA4;
      4'd3:    pat = 8'hB0;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h92;
      4'd6:    pat = 8'h82;
      4'd7:    pat = 8'hF8;
      4'd8:    pat = 8'h80;
      4'd9:    pat = 8'h90;
      default: pat = 8'hBF;
    endcase
    if (blank) pat = 8'hFF;
  end
endmodule

module game_time_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEAD_CYC  = 16,
  parameter int BLINK_DIV = 12500000,
  parameter int LZ_BLANK  = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  game_time_display_if.slave tif
);
  localparam int NUM_DIG = 3;
  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]               scan_cnt;
  logic [1:0]                      idx;
  logic [BLINK_W-1:0]              blink_cnt;
  logic                            blink_on;
  logic                            init_done;
  logic [NUM_DIG-1:0][3:0]         shd_dig;
  logic                            shd_max;
  logic [NUM_DIG-1:0][7:0]         dig_pat;
  logic [7:0]                      seg_q, seg_d;
  logic [2:0]                      sel_q, sel_d;
  logic                            scan_wrap, blink_wrap, snap;

  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  // Frame boundary (idx 2 -> 0) or the first cycle out of reset.
  assign snap       = !init_done || (scan_wrap && idx == 2'd2);

  generate
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
      logic blank;
      if (i == 0 || LZ_BLANK == 0) begin : g_nb
        assign blank = 1'b0;
      end else begin : g_lz
        // Blank only when this digit and every higher one are literal zero.
        always_comb begin
          blank = 1'b1;
          for (int j = i; j < NUM_DIG; j++)
            if (shd_dig[j] != 4'd0) blank = 1'b0;
        end
      end
      game_time_digit u_dig (
        .code  (shd_dig[i]),
        .blank (blank),
        .pat   (dig_pat[i])
      );
    end
  endgenerate

  always_comb begin
    seg_d = 8'hFF;
    sel_d = 3'b111;
    if (scan_cnt >= SCAN_W'(DEAD_CYC) && blink_on) begin
      seg_d = dig_pat[idx];
      sel_d = ~(3'b001 << idx);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      scan_cnt  <= '0;
      idx       <= 2'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      init_done <= 1'b0;
      shd_dig   <= '0;
      shd_max   <= 1'b0;
      seg_q     <= 8'hFF;
      sel_q     <= 3'b111;
    end else begin
      init_done <= 1'b1;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;

      if (snap) begin
        shd_dig[0] <= tif.time_1s;
        shd_dig[1] <= tif.time_10s;
        shd_dig[2] <= tif.time_100s;
        shd_max    <= tif.time_max_flag;
      end

      // Blink phase restarts lit whenever saturation clears at a snapshot.
      if (snap && !tif.time_max_flag) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (shd_max) begin
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
        if (blink_wrap) blink_on <= ~blink_on;
      end
    end
  end

  assign tif.seg = seg_q;
  assign tif.sel = sel_q;
endmodule

// File: tb/tb_game_time_display.sv
// Randomised and directed bench for game_time_display against a frame-arithmetic reference model.
module tb_game_time_display;
  localparam int SD = 8, DC = 2, BD = 32, FR = 3 * SD;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;

  game_time_display_if tif ();
  game_time_display_if tif0 ();

  game_time_display #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD), .LZ_BLANK(1)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tif       (tif)
  );

  game_time_display #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD), .LZ_BLANK(0)) dut0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tif       (tif0)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: k = edges since reset release; shadows hold the inputs seen at the
  // latest snapshot edge (k == 1 or every FR edges); m_s = edge where saturation began.
  int         k;
  logic [3:0] m_dig [3];
  logic       m_flag;
  int         m_s;
  logic [7:0] e_seg, e_seg0;
  logic [2:0] e_sel;
  logic [3:0] in_o, in_t, in_h;
  logic       in_f;
  logic [7:0] seg_tab [16];

  function automatic logic [7:0] ref_digit(input bit lz, input int ix);
    if (lz && ix == 2 && m_dig[2] == 4'd0) return 8'hFF;
    if (lz && ix == 1 && m_dig[2] == 4'd0 && m_dig[1] == 4'd0) return 8'hFF;
    return seg_tab[m_dig[ix]];
  endfunction

  task automatic set_in(input logic [3:0] o, input logic [3:0] t, input logic [3:0] h, input logic f);
    in_o = o; in_t = t; in_h = h; in_f = f;
    tif.time_1s  = o; tif.time_10s  = t; tif.time_100s  = h; tif.time_max_flag  = f;
    tif0.time_1s = o; tif0.time_10s = t; tif0.time_100s = h; tif0.time_max_flag = f;
  endtask

  task automatic tick();
    int p, sc, ix;
    bit lit;
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      k = 0; m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0; m_flag = 0; m_s = 0;
      e_seg = 8'hFF; e_seg0 = 8'hFF; e_sel = 3'b111;
    end else begin
      k++;
      p  = k - 1;
      sc = p % SD;
      ix = (p / SD) % 3;
      lit = (sc >= DC) && (!m_flag || (((k - 1 - m_s) / BD) % 2 == 0));
      if (lit) begin
        e_sel  = ~(3'b001 << ix);
        e_seg  = ref_digit(1'b1, ix);
        e_seg0 = ref_digit(1'b0, ix);
      end else begin
        e_sel = 3'b111; e_seg = 8'hFF; e_seg0 = 8'hFF;
      end
      if (k == 1 || k % FR == 0) begin
        if (in_f && !m_flag) m_s = k;
        m_flag = in_f;
        m_dig[0] = in_o; m_dig[1] = in_t; m_dig[2] = in_h;
      end
    end
    #1;
  endtask

  task automatic sync_frame();
    do tick(); while (k % FR != 0);
  endtask

  task automatic test_reset();
    set_in(4'd3, 4'd2, 4'd1, 1'b0);
    sys_rst_n = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (tif.seg !== 8'hFF || tif.sel !== 3'b111 || tif0.seg !== 8'hFF || tif0.sel !== 3'b111) begin
        errors++;
        $display("FAIL reset_hold seg=%h sel=%b want seg=ff sel=111", tif.seg, tif.sel);
      end
    end
    sys_rst_n = 1'b1;
    repeat (FR) begin
      tick();
      checks++;
      if (tif.seg !== e_seg || tif.sel !== e_sel || tif0.seg !== e_seg0 || tif0.sel !== e_sel) begin
        errors++;
        $display("FAIL reset_model k=%0d seg=%h/%h sel=%b/%b want seg=%h/%h sel=%b",
                 k, tif.seg, tif0.seg, tif.sel, tif0.sel, e_seg, e_seg0, e_sel);
      end
      if (k <= DC) begin
        checks++;
        if (tif.sel !== 3'b111) begin
          errors++;
          $display("FAIL reset_dead k=%0d sel=%b want 111", k, tif.sel);
        end
      end
      if (k == 3 || k == 11 || k == 19) begin
        checks++;
        if ((k == 3  && {tif.sel, tif.seg} !== {3'b110, 8'hB0}) ||
            (k == 11 && {tif.sel, tif.seg} !== {3'b101, 8'hA4}) ||
            (k == 19 && {tif.sel, tif.seg} !== {3'b011, 8'hF9})) begin
          errors++;
          $display("FAIL reset_first_digits k=%0d sel=%b seg=%h", k, tif.sel, tif.seg);
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [7:0] c1 [3];
    logic [7:0] c0 [3];
    int sc, slot;
    c1 = '{8'hF8, 8'hFF, 8'hFF};
    c0 = '{8'hF8, 8'hC0, 8'hC0};
    set_in(4'd7, 4'd0, 4'd0, 1'b0);
    sync_frame();
    repeat (FR) begin
      tick();
      sc   = (k - 1) % SD;
      slot = ((k - 1) % FR) / SD;
      checks++;
      if (tif.seg !== e_seg || tif.sel !== e_sel || tif0.seg !== e_seg0 || tif0.sel !== e_sel) begin
        errors++;
        $display("FAIL lz_model k=%0d seg=%h/%h sel=%b want seg=%h/%h sel=%b",
                 k, tif.seg, tif0.seg, tif.sel, e_seg, e_seg0, e_sel);
      end
      if (sc >= DC) begin
        checks++;
        if (tif.seg !== c1[slot] || tif0.seg !== c0[slot]) begin
          errors++;
          $display("FAIL lz_slot slot=%0d seg=%h/%h want %h/%h", slot, tif.seg, tif0.seg, c1[slot], c0[slot]);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int sc, slot, frame;
    set_in(4'd3, 4'd2, 4'd1, 1'b0);
    sync_frame();
    for (frame = 0; frame < 2; frame++) begin
      repeat (FR) begin
        tick();
        sc   = (k - 1) % SD;
        slot = ((k - 1) % FR) / SD;
        // Frame 0: ones goes 3->4 in the tens slot; frame 1: 4->5 before ones lights.
        if (frame == 0 && slot == 1 && sc == 4) set_in(4'd4, 4'd2, 4'd1, 1'b0);
        if (frame == 1 && slot == 0 && sc == 1) set_in(4'd5, 4'd2, 4'd1, 1'b0);
        checks++;
        if (tif.seg !== e_seg || tif.sel !== e_sel || tif0.seg !== e_seg0) begin
          errors++;
          $display("FAIL snap_model k=%0d seg=%h sel=%b want seg=%h sel=%b", k, tif.seg, tif.sel, e_seg, e_sel);
        end
        if (slot == 0 && sc >= DC) begin
          checks++;
          if (tif.seg !== ((frame == 0) ? 8'hB0 : 8'h99)) begin
            errors++;
            $display("FAIL snap_ones frame=%0d seg=%h want %h", frame, tif.seg, (frame == 0) ? 8'hB0 : 8'h99);
          end
        end
      end
    end
  endtask

  task automatic test_dash();
    int sc, slot;
    set_in(4'd5, 4'd12, 4'd0, 1'b0);
    sync_frame();
    repeat (FR) begin
      tick();
      sc   = (k - 1) % SD;
      slot = ((k - 1) % FR) / SD;
      checks++;
      if (tif.seg !== e_seg || tif.sel !== e_sel || tif0.seg !== e_seg0) begin
        errors++;
        $display("FAIL dash_model k=%0d seg=%h/%h want %h/%h", k, tif.seg, tif0.seg, e_seg, e_seg0);
      end
      if (sc >= DC && slot > 0) begin
        checks++;
        if ((slot == 1 && tif.seg !== 8'hBF) || (slot == 2 && (tif.seg !== 8'hFF || tif0.seg !== 8'hC0))) begin
          errors++;
          $display("FAIL dash_slot slot=%0d seg=%h/%h", slot, tif.seg, tif0.seg);
        end
      end
    end
  endtask

  task automatic test_blink();
    int s0;
    set_in(4'd9, 4'd9, 4'd9, 1'b1);
    sync_frame();
    s0 = k;
    repeat (6 * FR) begin
      tick();
      checks++;
      if (tif.seg !== e_seg || tif.sel !== e_sel || tif0.sel !== e_sel) begin
        errors++;
        $display("FAIL blink_model k=%0d seg=%h sel=%b want seg=%h sel=%b", k, tif.seg, tif.sel, e_seg, e_sel);
      end
      if (k - s0 == 3 || (k - s0 > BD && k - s0 <= 2 * BD)) begin
        checks++;
        if ((k - s0 == 3 && {tif.sel, tif.seg} !== {3'b110, 8'h90}) ||
            (k - s0 > BD && {tif.sel, tif.seg} !== {3'b111, 8'hFF})) begin
          errors++;
          $display("FAIL blink_phase off=%0d sel=%b seg=%h", k - s0, tif.sel, tif.seg);
        end
      end
    end
    set_in(4'd9, 4'd9, 4'd9, 1'b0);
    sync_frame();
    s0 = k;
    repeat (FR) begin
      tick();
      checks++;
      if (tif.seg !== e_seg || tif.sel !== e_sel) begin
        errors++;
        $display("FAIL blink_clear_model k=%0d seg=%h sel=%b want seg=%h sel=%b", k, tif.seg, tif.sel, e_seg, e_sel);
      end
      if (k - s0 == 3) begin
        checks++;
        if ({tif.sel, tif.seg} !== {3'b110, 8'h90}) begin
          errors++;
          $display("FAIL blink_resume sel=%b seg=%h want 110/90", tif.sel, tif.seg);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] h;
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0) begin
        h = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
        set_in(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), h, $urandom_range(0, 3) == 0);
      end
      tick();
      checks++;
      if (tif.seg !== e_seg || tif.sel !== e_sel || tif0.seg !== e_seg0 || tif0.sel !== e_sel) begin
        errors++;
        $display("FAIL random_model k=%0d seg=%h/%h sel=%b/%b want seg=%h/%h sel=%b",
                 k, tif.seg, tif0.seg, tif.sel, tif0.sel, e_seg, e_seg0, e_sel);
      end
      checks++;
      if ($countones(~tif.sel) > 1 || (tif.sel === 3'b111 && tif.seg !== 8'hFF)) begin
        errors++;
        $display("FAIL random_invariant sel=%b seg=%h", tif.sel, tif.seg);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_in(4'd3, 4'd2, 4'd1, 1'b0);
    n = 0;
    while (k % FR != 13 && n < 2 * FR) begin
      tick();
      n++;
    end
    checks++;
    if (k % FR != 13) begin
      errors++;
      $display("FAIL reset_mid_align k=%0d want k%%%0d==13", k, FR);
    end
    sys_rst_n = 1'b0;
    tick();
    checks++;
    if (tif.seg !== 8'hFF || tif.sel !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid_abort seg=%h sel=%b want ff/111", tif.seg, tif.sel);
    end
    sys_rst_n = 1'b1;
    repeat (FR) begin
      tick();
      checks++;
      if (tif.seg !== e_seg || tif.sel !== e_sel || $countones(~tif.sel) > 1) begin
        errors++;
        $display("FAIL reset_mid_model k=%0d seg=%h sel=%b want seg=%h sel=%b", k, tif.seg, tif.sel, e_seg, e_sel);
      end
      if (k == DC + 1) begin
        checks++;
        if ({tif.sel, tif.seg} !== {3'b110, 8'hB0}) begin
          errors++;
          $display("FAIL reset_mid_idx0 sel=%b seg=%h want 110/b0", tif.sel, tif.seg);
        end
      end
    end
  endtask

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    k = 0; m_flag = 0; m_s = 0;
    set_in(4'd0, 4'd0, 4'd0, 1'b0);
    test_reset();
    test_lz_blank();
    test_snapshot();
    test_dash();
    test_blink();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
